// File: rtl/pio_input_debounced_irq_pkg.sv
// Shared constants for the debounced PIO input port: register word addresses
// and edge-mode encodings, plus a small bus-decode helper.
package pio_input_debounced_irq_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RAW  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic logic write_hit(input logic chipselect, input logic write,
                                     input logic [1:0] address, input logic [1:0] target);
    return chipselect & write & (address == target);
  endfunction

endpackage

// File: rtl/pio_input_debounced_irq_debounce_bit.sv
// One debounce lane: a mismatch-streak counter advanced on shared ticks and
// the filtered flop it guards.
module pio_debounce_bit #(
  parameter int STABLE_TICKS = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic d,
  output logic filtered
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [CW-1:0] cnt;

  // Any cycle where the input agrees with the filtered state breaks the streak.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      filtered <= 1'b0;
    end else if (d == filtered) begin
      cnt <= '0;
    end else if (tick) begin
      if (cnt == CNT_LAST) begin
        filtered <= d;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pio_input_debounced_irq.sv
// Avalon-MM PIO input port: synchronised, debounced inputs with sticky
// edge capture, per-bit interrupt mask and a level IRQ.
module pio_input_debounced_irq
  import pio_input_debounced_irq_pkg::*;
#(
  parameter int WIDTH        = 10,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 5,
  parameter int EDGE_MODE    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]    pre;
  logic             tick;
  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] filtered;
  logic [WIDTH-1:0] filtered_d;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] clear;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      rd_next;
  logic             wr_mask;
  logic             wr_edge;
  logic             unused_wdata;

  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= in_port;
      sync <= meta;
    end
  end

  // With TICK_DIV = 1 the counter is pinned at 0 and tick is constantly high.
  assign tick = (pre == PRE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + PW'(1);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .d        (sync[i]),
      .filtered (filtered[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) filtered_d <= '0;
    else       filtered_d <= filtered;
  end

  always_comb begin
    edge_vec = '0;
    case (EDGE_MODE)
      EDGE_RISE: edge_vec = filtered & ~filtered_d;
      EDGE_FALL: edge_vec = ~filtered & filtered_d;
      default:   edge_vec = filtered ^ filtered_d;
    endcase
  end

  assign wr_mask = write_hit(chipselect, write, address, ADDR_MASK);
  assign wr_edge = write_hit(chipselect, write, address, ADDR_EDGE);
  assign clear   = wr_edge ? wdata : '0;

  // Edge term is OR'd after the clear so a coincident edge survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_mask) irq_mask <= wdata;
      edge_capture <= (edge_capture & ~clear) | edge_vec;
    end
  end

  assign irq = |(edge_capture & irq_mask);

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA: rd_next[WIDTH-1:0] = filtered;
      ADDR_RAW:  rd_next[WIDTH-1:0] = sync;
      ADDR_MASK: rd_next[WIDTH-1:0] = irq_mask;
      default:   rd_next[WIDTH-1:0] = edge_capture;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_next;
  end

endmodule

// File: tb/tb_pio_input_debounced_irq.sv
// Bench for pio_input_debounced_irq: three instances (rise/fall/any edge modes)
// share stimulus; reads are checked through an expected-value queue.
module tb_pio_input_debounced_irq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [9:0]  in_port = '0;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  always #5 clk = ~clk;

  pio_input_debounced_irq #(.WIDTH(10), .TICK_DIV(4), .STABLE_TICKS(3), .EDGE_MODE(0)) dut0 (
    .clk(clk), .reset(rst), .address(address), .chipselect(chipselect), .write(write),
    .writedata(writedata), .readdata(rd0), .in_port(in_port), .irq(irq0));
  pio_input_debounced_irq #(.WIDTH(10), .TICK_DIV(4), .STABLE_TICKS(3), .EDGE_MODE(1)) dut1 (
    .clk(clk), .reset(rst), .address(address), .chipselect(chipselect), .write(write),
    .writedata(writedata), .readdata(rd1), .in_port(in_port), .irq(irq1));
  pio_input_debounced_irq #(.WIDTH(10), .TICK_DIV(4), .STABLE_TICKS(3), .EDGE_MODE(2)) dut2 (
    .clk(clk), .reset(rst), .address(address), .chipselect(chipselect), .write(write),
    .writedata(writedata), .readdata(rd2), .in_port(in_port), .irq(irq2));

  // Cycle count since reset release; tick fires on posedges where cyc % 4 == 0.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int tests = 0;
  int fails = 0;
  int hi_bad = 0;

  always @(negedge clk)
    if (!rst && (((rd0 | rd1 | rd2) & 32'hFFFF_FC00) != 0)) hi_bad++;

  typedef struct {
    string       nm;
    int          which;
    logic [31:0] exp;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ra;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[5];

  function automatic logic [31:0] rd_of(input int w);
    case (w)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; writedata = '0;
  endtask

  task automatic read3(input logic [1:0] a, input string nm,
                       input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    sb_t e;
    sbq.push_back('{{nm, "_m0"}, 0, e0});
    sbq.push_back('{{nm, "_m1"}, 1, e1});
    sbq.push_back('{{nm, "_m2"}, 2, e2});
    address = a; chipselect = 1'b1; write = 1'b0;
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.nm, rd_of(e.which), e.exp);
    end
    chipselect = 1'b0;
  endtask

  // First tick posedge at which a change driven at negedge cycle n0 is counted.
  function automatic int first_tick(input int n0);
    int t = n0 + 3;
    while (t % 4 != 0) t++;
    return t;
  endfunction

  initial begin
    int early, found, bad, t_hit;

    vt[0] = '{2'd2, 32'hFFFF_FFFF, 2'd2, 32'h0000_03FF};
    vt[1] = '{2'd2, 32'h0000_0155, 2'd2, 32'h0000_0155};
    vt[2] = '{2'd0, 32'h0000_03FF, 2'd0, 32'h0000_0005};
    vt[3] = '{2'd1, 32'h0000_0000, 2'd1, 32'h0000_0005};
    vt[4] = '{2'd2, 32'h0000_0000, 2'd2, 32'h0000_0000};

    step(2);
    check("reset_readdata", rd0, 32'h0);
    check("reset_irq", 32'(irq2), 32'h0);
    rst = 1'b0;
    step(3);

    // Single bit held high: settles within the worst-case window, not before.
    in_port = 10'h001; address = 2'd0;
    early = 0;
    repeat (11) begin
      @(negedge clk);
      if (rd0 != 32'h0) early = 1;
    end
    check("t1_not_early", 32'(early), 32'h0);
    found = 0;
    for (int k = 0; k < 6 && found == 0; k++) begin
      @(negedge clk);
      if (rd0 == 32'h1) found = 1;
    end
    check("t1_settled", 32'(found), 32'h1);
    read3(2'd3, "t1_capture", 32'h001, 32'h000, 32'h001);
    check("t1_irq_masked", 32'(irq0), 32'h0);

    // Six-cycle glitch on bit 3 spans at most two ticks.
    in_port[3] = 1'b1; address = 2'd1;
    step(3);
    check("t2_raw_pulse", rd0, 32'h009);
    step(3);
    in_port[3] = 1'b0; address = 2'd0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (rd0[3]) bad++;
    end
    check("t2_filtered_b3", 32'(bad), 32'h0);
    read3(2'd3, "t2_capture", 32'h001, 32'h000, 32'h001);

    check("t3_irq_before", 32'(irq0), 32'h0);
    wr(2'd2, 32'h001);
    check("t3_irq_m0", 32'(irq0), 32'h1);
    check("t3_irq_m1", 32'(irq1), 32'h0);
    check("t3_irq_m2", 32'(irq2), 32'h1);
    wr(2'd3, 32'h001);
    check("t3_irq_clr_m0", 32'(irq0), 32'h0);
    check("t3_irq_clr_m2", 32'(irq2), 32'h0);
    read3(2'd3, "t3_capture", 32'h0, 32'h0, 32'h0);

    // Clear of bit 2 lands on the same edge that captures its rising edge.
    t_hit = first_tick(cyc) + 8;
    in_port[2] = 1'b1;
    for (int g = 0; g < 40 && cyc < t_hit; g++) @(negedge clk);
    check("t4_align", 32'(cyc), 32'(t_hit));
    wr(2'd3, 32'h004);
    read3(2'd3, "t4_edge_wins", 32'h004, 32'h000, 32'h004);
    wr(2'd3, 32'h000);
    read3(2'd3, "t4_write0", 32'h004, 32'h000, 32'h004);
    read3(2'd0, "t4_filtered", 32'h005, 32'h005, 32'h005);

    wr(2'd3, 32'h3FF);
    read3(2'd3, "t5_cleared", 32'h0, 32'h0, 32'h0);
    in_port[5] = 1'b1;
    step(20);
    read3(2'd3, "t5_rise", 32'h020, 32'h000, 32'h020);
    wr(2'd3, 32'h020);
    read3(2'd3, "t5_mid", 32'h0, 32'h0, 32'h0);
    in_port[5] = 1'b0;
    step(20);
    read3(2'd3, "t5_fall", 32'h000, 32'h020, 32'h020);

    for (int i = 0; i < 5; i++) begin
      wr(vt[i].wa, vt[i].wd);
      read3(vt[i].ra, $sformatf("vec%0d", i), vt[i].exp, vt[i].exp, vt[i].exp);
    end

    // Reset mid-debounce with counter at 2 and irq active on the capture modes.
    wr(2'd2, 32'h020);
    check("t6_irq_pre", 32'(irq1), 32'h1);
    t_hit = first_tick(cyc) + 4;
    in_port[7] = 1'b1;
    for (int g = 0; g < 40 && cyc < t_hit; g++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_rd0", rd0, 32'h0);
    check("t6_rst_rd1", rd1, 32'h0);
    check("t6_rst_irq1", 32'(irq1), 32'h0);
    check("t6_rst_irq2", 32'(irq2), 32'h0);
    @(negedge clk);
    rst = 1'b0; address = 2'd0;
    early = 0;
    repeat (12) begin
      @(negedge clk);
      if (rd0 != 32'h0) early = 1;
    end
    check("t6_full_streak", 32'(early), 32'h0);
    @(negedge clk);
    check("t6_settled", rd0, 32'h085);
    read3(2'd3, "t6_capture", 32'h085, 32'h000, 32'h085);
    check("t6_irq_mask_rst", 32'(irq0), 32'h0);
    check("hi_bits_zero", 32'(hi_bad), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
